// File: rtl/muldiv_unit_if.sv
// Purpose: operand/result handshake bundle between the execute stage and muldiv_unit.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, op (RV32M funct3), a, b, out_valid, out_ready, result.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;

  // Pipeline side drives requests and consumes results.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  // Execution unit side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: DATA_WIDTH+1 cycles accept-to-out_valid for all normal ops; 1 cycle for div-by-zero/overflow.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts at any time.
// Ports: clk, rst_n (async active-low), flush (sync abort), bus (muldiv_unit_if.slave).
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  muldiv_unit_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2*W-1:0]   acc_q, acc_d;      // product (mul) or {remainder, quotient} (div)
  logic [W-1:0]     opnd_q, opnd_d;    // multiplicand magnitude or divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;    // negate product / quotient at the end
  logic             rneg_q, rneg_d;    // negate remainder at the end
  logic             spec_q, spec_d;    // special case: acc_q[W-1:0] already holds the answer
  logic [W-1:0]     result_q, result_d;

  logic             accept;
  logic             a_sgn, b_sgn;
  logic [W-1:0]     a_mag, b_mag;
  logic             b_zero, ovf;
  logic [W:0]       mul_sum;
  logic [W:0]       div_shift;
  logic             div_ge;
  logic [W-1:0]     div_diff;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix, rem_fix;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid)               state_d = BUSY;
      BUSY: if (spec_q || cnt_q == '0)      state_d = DONE;
      DONE: if (bus.out_ready)              state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = result_q;
  end

  // ---------------- datapath ----------------
  assign accept = (state_q == IDLE) && bus.in_valid && !flush;

  always_comb begin
    a_sgn  = (bus.op == OP_MULH || bus.op == OP_MULHSU || bus.op == OP_DIV || bus.op == OP_REM)
             && bus.a[W-1];
    b_sgn  = (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM) && bus.b[W-1];
    a_mag  = a_sgn ? (~bus.a + 1'b1) : bus.a;
    b_mag  = b_sgn ? (~bus.b + 1'b1) : bus.b;
    b_zero = (bus.b == '0);
    ovf    = (bus.op == OP_DIV || bus.op == OP_REM)
             && (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == '1);

    // One shift-add step: conditionally add multiplicand into the high half, shift right.
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    // One restoring step: shift next dividend bit into the partial remainder, trial-subtract.
    div_shift = acc_q[2*W-1:W-1];
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[W-1:0] - opnd_q;   // exact when div_ge, since remainder < divisor

    prod_fix  = qneg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = qneg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem_fix   = rneg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
  end

  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    spec_d   = spec_q;
    result_d = result_q;

    if (accept) begin
      op_d   = bus.op;
      cnt_d  = CW'(W);
      qneg_d = a_sgn ^ b_sgn;
      rneg_d = a_sgn;
      spec_d = 1'b0;
      if (bus.op[2]) begin
        acc_d  = {{W{1'b0}}, a_mag};
        opnd_d = b_mag;
        if (b_zero) begin
          spec_d = 1'b1;
          acc_d  = {{W{1'b0}}, (bus.op[1] ? bus.a : {W{1'b1}})};
        end else if (ovf) begin
          spec_d = 1'b1;
          acc_d  = {{W{1'b0}}, (bus.op[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}})};
        end
      end else begin
        acc_d  = {{W{1'b0}}, b_mag};
        opnd_d = a_mag;
      end
    end else if (state_q == BUSY && !flush) begin
      if (spec_q) begin
        result_d = acc_q[W-1:0];
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
        if (op_q[2]) acc_d = div_ge ? {div_diff, acc_q[W-2:0], 1'b1}
                                    : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        else         acc_d = {mul_sum, acc_q[W-1:1]};
      end else begin
        unique case (op_q)
          OP_MUL:                        result_d = prod_fix[W-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*W-1:W];
          OP_DIV, OP_DIVU:               result_d = quo_fix;
          default:                       result_d = rem_fix;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
    end
  end
endmodule
